// File: rtl/memory_stage_if.sv
// EX/MEM input bundle and MEM/WB output bundle of the memory stage.
// The slave side is the memory stage; the master side is the pipeline around it.
interface memory_stage_if;
   logic        ex_valid;
   logic [1:0]  ctlwb_in;
   logic [2:0]  ctlm_in;
   logic [31:0] add_result;
   logic        zero;
   logic [31:0] alu_result;
   logic [31:0] rdata2;
   logic [4:0]  muxout;

   logic        stall;
   logic        pcsrc;
   logic [31:0] branch_target;
   logic        wb_valid;
   logic [1:0]  wb_ctl_out;
   logic [31:0] read_data_out;
   logic [31:0] alu_result_out;
   logic [4:0]  dest_reg_out;

   modport master (
      output ex_valid, ctlwb_in, ctlm_in, add_result, zero, alu_result, rdata2, muxout,
      input  stall, pcsrc, branch_target, wb_valid, wb_ctl_out, read_data_out,
             alu_result_out, dest_reg_out
   );

   modport slave (
      input  ex_valid, ctlwb_in, ctlm_in, add_result, zero, alu_result, rdata2, muxout,
      output stall, pcsrc, branch_target, wb_valid, wb_ctl_out, read_data_out,
             alu_result_out, dest_reg_out
   );
endinterface

// File: rtl/memory_stage.sv
// Pipeline MEM stage: multi-cycle data memory access with upstream stall,
// branch resolution and the MEM/WB pipeline register.
module memory_stage #(
   parameter int unsigned MEM_LATENCY = 2,
   parameter int unsigned ADDR_W      = 8
) (
   input logic           clk,
   input logic           reset,
   memory_stage_if.slave bus
);

   typedef enum logic {ST_IDLE, ST_BUSY} state_t;

   localparam logic [3:0] LP_CNT_INIT = 4'(MEM_LATENCY - 1);

   state_t             r_state;
   logic [3:0]         r_cnt;
   logic [31:0]        r_mem [2**ADDR_W];

   logic               r_wb_valid;
   logic [1:0]         r_wb_ctl;
   logic [31:0]        r_read_data;
   logic [31:0]        r_alu_result;
   logic [4:0]         r_dest_reg;

   logic               w_memop;
   logic               w_store;
   logic               w_done;
   logic [ADDR_W-1:0]  w_idx;
   logic               w_unused;

   assign w_memop  = bus.ex_valid & (bus.ctlm_in[1] | bus.ctlm_in[0]);
   assign w_store  = bus.ctlm_in[0];
   assign w_done   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
   assign w_idx    = bus.alu_result[ADDR_W+1:2];
   assign w_unused = ^{bus.alu_result[1:0], bus.alu_result[31:ADDR_W+2]};

   assign bus.stall = ~reset & (((r_state == ST_IDLE) & w_memop) |
                                ((r_state == ST_BUSY) & (r_cnt != 4'd0)));
   assign bus.pcsrc         = bus.ex_valid & bus.ctlm_in[2] & bus.zero & (r_state == ST_IDLE);
   assign bus.branch_target = bus.add_result;

   assign bus.wb_valid       = r_wb_valid;
   assign bus.wb_ctl_out     = r_wb_ctl;
   assign bus.read_data_out  = r_read_data;
   assign bus.alu_result_out = r_alu_result;
   assign bus.dest_reg_out   = r_dest_reg;

   // Memory has no reset; an async reset drops r_state to IDLE before the
   // completing edge, so an abandoned store never reaches the array.
   always_ff @(posedge clk) begin
      if (!reset && w_done && w_store) begin
         r_mem[w_idx] <= bus.rdata2;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= ST_IDLE;
         r_cnt        <= '0;
         r_wb_valid   <= 1'b0;
         r_wb_ctl     <= '0;
         r_read_data  <= '0;
         r_alu_result <= '0;
         r_dest_reg   <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_memop) begin
                  r_state    <= ST_BUSY;
                  r_cnt      <= LP_CNT_INIT;
                  r_wb_valid <= 1'b0;
                  r_wb_ctl   <= '0;
               end else if (bus.ex_valid) begin
                  r_wb_valid   <= 1'b1;
                  r_wb_ctl     <= bus.ctlwb_in;
                  r_read_data  <= '0;
                  r_alu_result <= bus.alu_result;
                  r_dest_reg   <= bus.muxout;
               end else begin
                  r_wb_valid <= 1'b0;
                  r_wb_ctl   <= '0;
               end
            end
            ST_BUSY: begin
               if (r_cnt != 4'd0) begin
                  r_cnt      <= r_cnt - 4'd1;
                  r_wb_valid <= 1'b0;
                  r_wb_ctl   <= '0;
               end else begin
                  // Load returns the pre-write contents of the addressed word.
                  r_state      <= ST_IDLE;
                  r_wb_valid   <= 1'b1;
                  r_wb_ctl     <= bus.ctlwb_in;
                  r_read_data  <= w_store ? '0 : r_mem[w_idx];
                  r_alu_result <= bus.alu_result;
                  r_dest_reg   <= bus.muxout;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: stimulus pushes expected MEM/WB bundles,
// a monitor pops and compares on every wb_valid.
module tb_memory_stage;

   typedef struct packed {
      logic [1:0]  ctl;
      logic [31:0] rd;
      logic [31:0] alu;
      logic [4:0]  dst;
   } wb_t;

   logic clk;
   logic reset;
   int   checks;
   int   errors;
   wb_t  sb[$];

   memory_stage_if bus();

   memory_stage #(.MEM_LATENCY(2), .ADDR_W(8)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // Monitor: compares every presented MEM/WB bundle against the queue head.
   initial begin
      wb_t e;
      forever begin
         @(negedge clk);
         if (bus.wb_valid === 1'b1) begin
            if (sb.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_wb_valid actual=1 required=0");
            end else begin
               e = sb.pop_front();
               chk("wb_ctl_out", {30'd0, bus.wb_ctl_out}, {30'd0, e.ctl});
               chk("read_data_out", bus.read_data_out, e.rd);
               chk("alu_result_out", bus.alu_result_out, e.alu);
               chk("dest_reg_out", {27'd0, bus.dest_reg_out}, {27'd0, e.dst});
            end
         end else begin
            chk("bubble_wb_ctl", {30'd0, bus.wb_ctl_out}, 32'd0);
         end
      end
   end

   task automatic drive_idle();
      bus.ex_valid   = 1'b0;
      bus.ctlwb_in   = '0;
      bus.ctlm_in    = '0;
      bus.add_result = '0;
      bus.zero       = 1'b0;
      bus.alu_result = '0;
      bus.rdata2     = '0;
      bus.muxout     = '0;
   endtask

   task automatic idle(input int n);
      drive_idle();
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Presents one bundle, holds it while stalled, counts stall cycles.
   // Called and returns at posedge+1; the bundle is accepted at the last edge.
   task automatic send(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] alu,
                       input logic [31:0] wd, input logic [4:0] dst,
                       input int exp_stalls, input logic [31:0] exp_rd);
      int n;
      bit done;
      n = 0;
      done = 1'b0;
      bus.ex_valid   = 1'b1;
      bus.ctlwb_in   = wb;
      bus.ctlm_in    = m;
      bus.alu_result = alu;
      bus.rdata2     = wd;
      bus.muxout     = dst;
      bus.zero       = 1'b0;
      sb.push_back('{wb, exp_rd, alu, dst});
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (bus.stall === 1'b1) n++;
         else done = 1'b1;
         @(posedge clk);
         #1;
      end
      if (!done) begin
         checks++;
         errors++;
         $display("FAIL stall_timeout actual=%0d required=%0d", n, exp_stalls);
      end else begin
         chk("stall_cycles", n, exp_stalls);
      end
   endtask

   initial begin
      checks = 0;
      errors = 0;
      drive_idle();
      reset = 1'b1;

      // Reset state, and stall suppressed under reset even with a memop present
      @(negedge clk);
      chk("rst_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("rst_read_data", bus.read_data_out, 32'd0);
      chk("rst_alu_out", bus.alu_result_out, 32'd0);
      chk("rst_dest", {27'd0, bus.dest_reg_out}, 32'd0);
      chk("rst_pcsrc", {31'd0, bus.pcsrc}, 32'd0);
      bus.ex_valid = 1'b1;
      bus.ctlm_in  = 3'b010;
      #1;
      chk("rst_stall", {31'd0, bus.stall}, 32'd0);
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("idle_stall", {31'd0, bus.stall}, 32'd0);

      // Store then load at 0x10
      send(2'b00, 3'b001, 32'h10, 32'hDEADBEEF, 5'd0, 2, 32'h0);
      idle(1);
      send(2'b11, 3'b010, 32'h10, 32'h0, 5'd7, 2, 32'hDEADBEEF);
      idle(2);

      // R-type, latency 1, no stall
      send(2'b10, 3'b000, 32'h5, 32'h0, 5'd5, 0, 32'h0);
      idle(2);

      // Branch resolution, combinational
      bus.ex_valid   = 1'b1;
      bus.ctlm_in    = 3'b100;
      bus.add_result = 32'h40;
      bus.zero       = 1'b1;
      bus.alu_result = 32'h0;
      bus.muxout     = 5'd0;
      bus.ctlwb_in   = 2'b00;
      sb.push_back('{2'b00, 32'h0, 32'h0, 5'd0});
      @(negedge clk);
      chk("pcsrc_taken", {31'd0, bus.pcsrc}, 32'd1);
      chk("branch_target", bus.branch_target, 32'h40);
      @(posedge clk);
      #1;
      bus.zero = 1'b0;
      sb.push_back('{2'b00, 32'h0, 32'h0, 5'd0});
      @(negedge clk);
      chk("pcsrc_not_taken", {31'd0, bus.pcsrc}, 32'd0);
      @(posedge clk);
      #1;
      idle(2);

      // memread+memwrite together acts as a store
      send(2'b00, 3'b011, 32'h30, 32'h12345678, 5'd1, 2, 32'h0);
      send(2'b10, 3'b010, 32'h30, 32'h0, 5'd2, 2, 32'h12345678);
      idle(2);

      // Reset mid-BUSY abandons the pending store
      send(2'b00, 3'b001, 32'h20, 32'h11111111, 5'd0, 2, 32'h0);
      idle(2);
      bus.ex_valid   = 1'b1;
      bus.ctlm_in    = 3'b001;
      bus.alu_result = 32'h20;
      bus.rdata2     = 32'h22222222;
      bus.muxout     = 5'd9;
      @(posedge clk);
      #1;
      chk("busy_stall", {31'd0, bus.stall}, 32'd1);
      #2;
      reset = 1'b1;
      #1;
      chk("midbusy_stall", {31'd0, bus.stall}, 32'd0);
      chk("midbusy_wb_valid", {31'd0, bus.wb_valid}, 32'd0);
      chk("midbusy_alu_out", bus.alu_result_out, 32'd0);
      chk("midbusy_dest", {27'd0, bus.dest_reg_out}, 32'd0);
      drive_idle();
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      send(2'b11, 3'b010, 32'h20, 32'h0, 5'd3, 2, 32'h11111111);
      idle(2);

      // Address wrap: 0x400 maps to word 0; low byte bits ignored
      send(2'b00, 3'b001, 32'h400, 32'hA5A5A5A5, 5'd0, 2, 32'h0);
      idle(1);
      send(2'b11, 3'b010, 32'h0, 32'h0, 5'd4, 2, 32'hA5A5A5A5);
      idle(1);

      // Back-to-back loads
      send(2'b11, 3'b010, 32'h13, 32'h0, 5'd10, 2, 32'hDEADBEEF);
      send(2'b11, 3'b010, 32'h0, 32'h0, 5'd11, 2, 32'hA5A5A5A5);
      idle(4);

      chk("scoreboard_drained", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
